// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The FIFO takes the slave side; the producer/consumer takes the master side.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic              rd_en;
   logic              flush;
   logic [DATA_W-1:0] buf_in;
   logic [DATA_W-1:0] buf_out;
   logic              buf_empty;
   logic              buf_full;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     fifo_counter;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, rd_en, flush, buf_in,
      input  buf_out, buf_empty, buf_full, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en, flush, buf_in,
      output buf_out, buf_empty, buf_full, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered status flags, sticky over/underflow
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   sync_fifo_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_q, count_nxt;
   logic              empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
   logic              wr_ok, rd_ok;

   // A full FIFO still accepts a write when the same edge frees a slot.
   always_comb begin
      rd_ok     = bus.rd_en && !empty_q;
      wr_ok     = bus.wr_en && (!full_q || bus.rd_en);
      count_nxt = count_q;
      if (bus.flush)
         count_nxt = '0;
      else if (wr_ok && !rd_ok)
         count_nxt = count_q + 1'b1;
      else if (rd_ok && !wr_ok)
         count_nxt = count_q - 1'b1;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == FULL_CNT);
         af_q    <= (count_nxt >= AF_CNT);
         ae_q    <= (count_nxt <= AE_CNT);
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
         end else begin
            if (wr_ok)                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)                rd_ptr <= rd_ptr + 1'b1;
            if (bus.wr_en && !wr_ok)  ovf_q  <= 1'b1;
            if (bus.rd_en && !rd_ok)  unf_q  <= 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (wr_ok && !bus.flush)
         mem[wr_ptr] <= bus.buf_in;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [DATA_W-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rdata_q <= '0;
            else if (bus.flush)
               rdata_q <= '0;
            else if (rd_ok)
               rdata_q <= mem[rd_ptr];
         end
         assign bus.buf_out = rdata_q;
      end else begin : g_fwft
         // Forced to zero while empty so the output never shows stale or unset storage.
         assign bus.buf_out = empty_q ? '0 : mem[rd_ptr];
      end
   endgenerate

   assign bus.buf_empty    = empty_q;
   assign bus.buf_full     = full_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.fifo_counter = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and a FWFT instance with identical stimulus and
// compares both against a queue-based model of the FIFO.
module tb_sync_fifo_param;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AF     = DEPTH - 2;
   localparam int AE     = 2;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int SW     = CW + 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_r ();
   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_f ();

   sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
      .clk(clk), .rst_n(rst_n), .bus(bus_r.slave));
   sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
      .clk(clk), .rst_n(rst_n), .bus(bus_f.slave));

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of stored words plus sticky flags.
   logic [DATA_W-1:0] q [$];
   logic [DATA_W-1:0] m_out;
   bit                m_ovf, m_unf;

   task automatic model_clear();
      q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   function automatic logic [SW-1:0] exp_status();
      return {CW'(q.size()), q.size() == 0, q.size() == DEPTH,
              q.size() >= AF, q.size() <= AE, m_ovf, m_unf};
   endfunction

   function automatic logic [SW-1:0] obs_status_r();
      return {bus_r.fifo_counter, bus_r.buf_empty, bus_r.buf_full,
              bus_r.almost_full, bus_r.almost_empty, bus_r.overflow, bus_r.underflow};
   endfunction

   function automatic logic [SW-1:0] obs_status_f();
      return {bus_f.fifo_counter, bus_f.buf_empty, bus_f.buf_full,
              bus_f.almost_full, bus_f.almost_empty, bus_f.overflow, bus_f.underflow};
   endfunction

   task automatic drive(input bit w, input bit r, input bit f, input logic [DATA_W-1:0] d);
      bus_r.wr_en = w; bus_r.rd_en = r; bus_r.flush = f; bus_r.buf_in = d;
      bus_f.wr_en = w; bus_f.rd_en = r; bus_f.flush = f; bus_f.buf_in = d;
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, settle 1 ns.
   task automatic cycle(input bit w, input bit r, input bit f, input logic [DATA_W-1:0] d);
      bit rd_acc, wr_acc;
      @(negedge clk);
      drive(w, r, f, d);
      @(posedge clk);
      if (f) begin
         model_clear();
      end else begin
         rd_acc = r && (q.size() > 0);
         wr_acc = w && ((q.size() < DEPTH) || rd_acc);
         if (w && !wr_acc) m_ovf = 1'b1;
         if (r && !rd_acc) m_unf = 1'b1;
         if (rd_acc) m_out = q.pop_front();
         if (wr_acc) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      logic [SW-1:0] rst_vec;
      rst_vec = {CW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs_status_r() !== rst_vec) begin
         errors++;
         $display("FAIL reset_status_reg: got %h want %h", obs_status_r(), rst_vec);
      end
      checks++;
      if (obs_status_f() !== rst_vec) begin
         errors++;
         $display("FAIL reset_status_fwft: got %h want %h", obs_status_f(), rst_vec);
      end
      checks++;
      if (bus_r.buf_out !== '0) begin
         errors++;
         $display("FAIL reset_buf_out: got %0d want 0", bus_r.buf_out);
      end
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] vals [4];
      vals = '{8'd100, 8'd64, 8'd36, 8'd12};
      foreach (vals[i]) cycle(1, 0, 0, vals[i]);
      checks++;
      if (bus_r.fifo_counter !== CW'(4)) begin
         errors++;
         $display("FAIL basic_count_full: got %0d want 4", bus_r.fifo_counter);
      end
      foreach (vals[i]) begin
         checks++;
         if (bus_f.buf_out !== vals[i]) begin
            errors++;
            $display("FAIL basic_fwft_head[%0d]: got %0d want %0d", i, bus_f.buf_out, vals[i]);
         end
         cycle(0, 1, 0, '0);
         checks++;
         if (bus_r.buf_out !== vals[i]) begin
            errors++;
            $display("FAIL basic_read[%0d]: got %0d want %0d", i, bus_r.buf_out, vals[i]);
         end
      end
      checks++;
      if (bus_r.fifo_counter !== CW'(0) || bus_r.buf_empty !== 1'b1) begin
         errors++;
         $display("FAIL basic_drained: count %0d empty %b want 0 1",
                  bus_r.fifo_counter, bus_r.buf_empty);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 0, 0, DATA_W'(i));
         checks++;
         if (bus_r.almost_full !== (i + 1 >= AF) || bus_r.buf_full !== (i + 1 == DEPTH)) begin
            errors++;
            $display("FAIL fill_flags[%0d]: af %b full %b want %b %b", i + 1,
                     bus_r.almost_full, bus_r.buf_full, i + 1 >= AF, i + 1 == DEPTH);
         end
      end
      cycle(1, 0, 0, 8'd99);
      checks++;
      if (bus_r.overflow !== 1'b1 || bus_r.fifo_counter !== CW'(DEPTH)) begin
         errors++;
         $display("FAIL overflow_set: ovf %b count %0d want 1 %0d",
                  bus_r.overflow, bus_r.fifo_counter, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 1, 0, '0);
         checks++;
         if (bus_r.buf_out !== DATA_W'(i)) begin
            errors++;
            $display("FAIL overflow_readback[%0d]: got %0d want %0d", i, bus_r.buf_out, i);
         end
      end
      checks++;
      if (bus_r.overflow !== 1'b1 || bus_f.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b/%b want 1", bus_r.overflow, bus_f.overflow);
      end
   endtask

   task automatic test_back_to_back();
      cycle(0, 0, 1, '0);
      checks++;
      if (bus_r.overflow !== 1'b0) begin
         errors++;
         $display("FAIL flush_clears_ovf: got %b want 0", bus_r.overflow);
      end
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, DATA_W'(i));
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (bus_f.buf_out !== DATA_W'(k)) begin
            errors++;
            $display("FAIL b2b_fwft_head[%0d]: got %0d want %0d", k, bus_f.buf_out, k);
         end
         cycle(1, 1, 0, DATA_W'(DEPTH + k));
         checks++;
         if (bus_r.buf_out !== DATA_W'(k) || bus_r.fifo_counter !== CW'(DEPTH) ||
             bus_r.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b[%0d]: out %0d count %0d ovf %b want %0d %0d 0", k,
                     bus_r.buf_out, bus_r.fifo_counter, bus_r.overflow, k, DEPTH);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 1, 0, '0);
         checks++;
         if (bus_r.buf_out !== DATA_W'(20 + i)) begin
            errors++;
            $display("FAIL b2b_drain[%0d]: got %0d want %0d", i, bus_r.buf_out, 20 + i);
         end
      end
   endtask

   task automatic test_underflow();
      cycle(0, 0, 1, '0);
      cycle(0, 1, 0, '0);
      checks++;
      if (bus_r.underflow !== 1'b1 || bus_r.fifo_counter !== CW'(0)) begin
         errors++;
         $display("FAIL underflow_set: unf %b count %0d want 1 0",
                  bus_r.underflow, bus_r.fifo_counter);
      end
      cycle(1, 1, 0, 8'd55);
      checks++;
      if (bus_r.fifo_counter !== CW'(1) || bus_r.buf_out !== '0 || bus_r.underflow !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw: count %0d out %0d unf %b want 1 0 1",
                  bus_r.fifo_counter, bus_r.buf_out, bus_r.underflow);
      end
      cycle(0, 0, 1, '0);
      checks++;
      if (bus_r.underflow !== 1'b0 || bus_r.fifo_counter !== CW'(0)) begin
         errors++;
         $display("FAIL flush_clears_unf: unf %b count %0d want 0 0",
                  bus_r.underflow, bus_r.fifo_counter);
      end
   endtask

   task automatic test_fwft();
      cycle(1, 0, 0, 8'd36);
      checks++;
      if (bus_f.buf_out !== 8'd36 || bus_f.buf_empty !== 1'b0) begin
         errors++;
         $display("FAIL fwft_fall_through: out %0d empty %b want 36 0",
                  bus_f.buf_out, bus_f.buf_empty);
      end
      cycle(0, 1, 0, '0);
      checks++;
      if (bus_f.buf_empty !== 1'b1 || bus_r.buf_out !== 8'd36) begin
         errors++;
         $display("FAIL fwft_read: empty %b reg_out %0d want 1 36",
                  bus_f.buf_empty, bus_r.buf_out);
      end
   endtask

   task automatic test_reset_mid();
      logic [SW-1:0] rst_vec;
      rst_vec = {CW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      cycle(0, 1, 0, '0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, DATA_W'($urandom_range(1, 255)));
      cycle(0, 1, 0, '0);
      @(negedge clk);
      drive(0, 0, 0, '0);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if (obs_status_r() !== rst_vec || bus_r.buf_out !== '0) begin
         errors++;
         $display("FAIL async_reset_reg: status %h out %0d want %h 0",
                  obs_status_r(), bus_r.buf_out, rst_vec);
      end
      checks++;
      if (obs_status_f() !== rst_vec) begin
         errors++;
         $display("FAIL async_reset_fwft: status %h want %h", obs_status_f(), rst_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 0, 0, 8'd12);
      cycle(0, 1, 0, '0);
      checks++;
      if (bus_r.buf_out !== 8'd12 || bus_r.fifo_counter !== CW'(0)) begin
         errors++;
         $display("FAIL post_reset_rw: out %0d count %0d want 12 0",
                  bus_r.buf_out, bus_r.fifo_counter);
      end
   endtask

   task automatic test_random();
      int wr_pct;
      cycle(0, 0, 1, '0);
      for (int n = 0; n < 600; n++) begin
         wr_pct = ((n / 60) % 2 == 0) ? 75 : 25;
         cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) >= wr_pct,
               $urandom_range(0, 79) == 0, DATA_W'($urandom));
         checks++;
         if (obs_status_r() !== exp_status() || bus_r.buf_out !== m_out) begin
            errors++;
            $display("FAIL rand_reg[%0d]: status %h out %0d want %h %0d", n,
                     obs_status_r(), bus_r.buf_out, exp_status(), m_out);
         end
         checks++;
         if (obs_status_f() !== exp_status() ||
             (q.size() > 0 && bus_f.buf_out !== q[0])) begin
            errors++;
            $display("FAIL rand_fwft[%0d]: status %h out %0d want %h %0d", n,
                     obs_status_f(), bus_f.buf_out, exp_status(),
                     (q.size() > 0) ? q[0] : '0);
         end
      end
   endtask

   initial begin
      drive(0, 0, 0, '0);
      model_clear();
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_fill_overflow();
      test_back_to_back();
      test_underflow();
      test_fwft();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
